// File: rtl/image_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : image_serial_tx_if
// Purpose  : Control, image-memory read and serial-line signals of image_serial_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface image_serial_tx_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] num_words;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              tx_line;
    logic              busy;
    logic              done;

    // master: the transmitter; slave: host control plus image memory
    modport master (
        input  start, base_addr, num_words, mem_rdata,
        output mem_rd, mem_addr, tx_line, busy, done
    );
    modport slave (
        output start, base_addr, num_words, mem_rdata,
        input  mem_rd, mem_addr, tx_line, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/image_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : image_serial_tx
// Purpose  : Fetches words from image memory and shifts each out LSB first as a
//            start/data/[parity]/stop frame. Define IMG_TX_PARITY_EN for even parity.
// Revision : 1.0 - initial release
// ============================================================================
module image_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    image_serial_tx_if.master bus
);
    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_idx_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_W - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [ADDR_W-1:0]  c_addr_one = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef IMG_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6,
        S_FIN    = 3'd7
    } state_t;

    state_t            r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_idx_w-1:0] r_idx;
    logic [DATA_W-1:0] r_shift;
    logic [ADDR_W-1:0] r_remaining;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_tx_line;
    logic              r_busy;
    logic              r_done;
`ifdef IMG_TX_PARITY_EN
    logic              r_parity;
`endif
    logic              w_line;
    logic              w_tick;

    assign bus.mem_rd   = r_mem_rd;
    assign bus.mem_addr = r_mem_addr;
    assign bus.tx_line  = r_tx_line;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

    assign w_tick = (r_cnt == c_cnt_last);

    // Line level for the current state; registered next edge, so the line trails the state by one cycle.
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = r_shift[0];
`ifdef IMG_TX_PARITY_EN
            S_PARITY: w_line = r_parity;
`endif
            default:  w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_remaining <= '0;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_tx_line   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef IMG_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_tx_line <= w_line;
            r_mem_rd  <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is dropped; it is re-sampled next cycle.
                    if (bus.start && !r_done) begin
                        r_mem_addr  <= bus.base_addr;
                        r_remaining <= bus.num_words;
                        r_busy      <= 1'b1;
                        if (bus.num_words == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_mem_rd <= 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end
                end
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    r_shift     <= bus.mem_rdata;
`ifdef IMG_TX_PARITY_EN
                    r_parity    <= ^bus.mem_rdata;
`endif
                    r_mem_addr  <= r_mem_addr + c_addr_one;
                    r_remaining <= r_remaining - c_addr_one;
                    r_cnt       <= '0;
                    r_idx       <= '0;
                    r_state     <= S_START;
                end
                S_START: begin
                    r_cnt <= w_tick ? '0 : r_cnt + c_cnt_one;
                    if (w_tick) r_state <= S_DATA;
                end
                S_DATA: begin
                    r_cnt <= w_tick ? '0 : r_cnt + c_cnt_one;
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_idx == c_idx_last) begin
                            r_idx <= '0;
`ifdef IMG_TX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + c_idx_one;
                        end
                    end
                end
`ifdef IMG_TX_PARITY_EN
                S_PARITY: begin
                    r_cnt <= w_tick ? '0 : r_cnt + c_cnt_one;
                    if (w_tick) r_state <= S_STOP;
                end
`endif
                S_STOP: begin
                    r_cnt <= w_tick ? '0 : r_cnt + c_cnt_one;
                    if (w_tick) begin
                        if (r_remaining != '0) begin
                            r_mem_rd <= 1'b1;
                            r_state  <= S_FETCH;
                        end else begin
                            r_state  <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_image_serial_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_image_serial_tx
// Purpose  : Scoreboard bench for image_serial_tx: expected reads, frames and done
//            pulses are queued with their cycle numbers and matched by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_serial_tx;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int CPB    = 4;
`ifdef IMG_TX_PARITY_EN
    localparam int NBITS  = DATA_W + 3;
`else
    localparam int NBITS  = DATA_W + 2;
`endif
    localparam int FLEN   = NBITS * CPB;
    localparam int PERIOD = FLEN + 2;

    typedef struct { int cyc; int addr; } addr_exp_t;
    typedef struct { int cyc; logic [15:0] bits; } frm_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    addr_exp_t exp_addr[$];
    frm_exp_t  exp_frm[$];
    int        exp_done[$];

    image_serial_tx_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    image_serial_tx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic report_unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d: event occurred, none expected", name, cyc);
    endtask

    // Reference frame: bit 0 start, data LSB first, optional even parity, stop (high).
    function automatic logic [15:0] frame_bits(input logic [DATA_W-1:0] d);
        logic [15:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) b[1 + i] = d[i];
`ifdef IMG_TX_PARITY_EN
        b[DATA_W + 1] = ^d;
`endif
        return b;
    endfunction

    // Transfer accepted at edge n: word i is read at n + i*PERIOD and its
    // start bit appears 3 cycles later; done follows the last stop bit.
    task automatic push_transfer(input int n, input int base, input int num, input int maxf);
        int a;
        if (num == 0) begin
            exp_done.push_back(n + 1);
        end else begin
            for (int i = 0; i < num && i < maxf; i++) begin
                a = (base + i) % (1 << ADDR_W);
                exp_addr.push_back('{n + i * PERIOD, a});
                exp_frm.push_back('{n + 3 + i * PERIOD, frame_bits(mem[a])});
            end
            if (num <= maxf) exp_done.push_back(n + 3 + (num - 1) * PERIOD + FLEN);
        end
    endtask

    task automatic do_start(input int base, input int num, input int maxf);
        logic [31:0] b;
        logic [31:0] m;
        b = base;
        m = num;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = b[15:0];
        bus.num_words = m[15:0];
        push_transfer(cyc + 1, base, num, maxf);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        bus.base_addr = 16'($urandom);
        bus.num_words = 16'($urandom);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_addr.size() != 0 || exp_frm.size() != 0 || exp_done.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) report_unexpected("drain_timeout");
        @(negedge clk);
    endtask

    // Monitor: matches every read strobe, line frame and done pulse against the queues.
    initial begin : monitor
        addr_exp_t ea;
        frm_exp_t  cur;
        int        ed;
        int        pos;
        bit        in_frame;
        pos = 0;
        in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                exp_addr.delete();
                exp_frm.delete();
                exp_done.delete();
            end else begin
                if (bus.mem_rd) begin
                    if (exp_addr.size() == 0) report_unexpected("mem_rd_unexpected");
                    else begin
                        ea = exp_addr.pop_front();
                        check("mem_rd_cycle", cyc, ea.cyc);
                        check("mem_addr", bus.mem_addr, ea.addr);
                    end
                end else if (exp_addr.size() != 0 && exp_addr[0].cyc < cyc) begin
                    ea = exp_addr.pop_front();
                    check("mem_rd_cycle", cyc, ea.cyc);
                end

                if (!in_frame) begin
                    if (exp_frm.size() != 0 && exp_frm[0].cyc < cyc) begin
                        cur = exp_frm.pop_front();
                        check("frame_start_cycle", cyc, cur.cyc);
                    end else if (bus.tx_line == 1'b0) begin
                        if (exp_frm.size() == 0) report_unexpected("tx_line_low_idle");
                        else begin
                            cur = exp_frm.pop_front();
                            check("frame_start_cycle", cyc, cur.cyc);
                            in_frame = 1'b1;
                            pos = 0;
                        end
                    end
                end
                if (in_frame) begin
                    check("tx_bit", bus.tx_line, cur.bits[pos / CPB]);
                    pos++;
                    if (pos == FLEN) in_frame = 1'b0;
                end

                if (bus.done) begin
                    if (exp_done.size() == 0) report_unexpected("done_unexpected");
                    else begin
                        ed = exp_done.pop_front();
                        check("done_cycle", cyc, ed);
                    end
                    check("busy_at_done", bus.busy, 0);
                end else if (exp_done.size() != 0 && exp_done[0] < cyc) begin
                    ed = exp_done.pop_front();
                    check("done_cycle", cyc, ed);
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int b;
        int n;
        int f2;
        int cnt;
        int num;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        foreach (mem[i]) mem[i] = DATA_W'($urandom);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_line", bus.tx_line, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_mem_rd", bus.mem_rd, 0);
        check("reset_mem_addr", bus.mem_addr, 0);
        rst_n = 1'b1;

        // single word
        mem[16'h0010] = 8'hA5;
        do_start(16'h0010, 1, 4);
        wait_drain(200);

        // burst with a start pulsed mid-frame that must be ignored
        b = $urandom_range(0, 16'hFFF0);
        mem[b] = 8'h00; mem[b + 1] = 8'hFF; mem[b + 2] = 8'h3C;
        do_start(b, 3, 4);
        repeat (20) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.base_addr = 16'h1234; bus.num_words = 16'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_drain(400);

        // zero length, then wrap-around
        do_start($urandom_range(0, 16'hFFFF), 0, 4);
        wait_drain(20);
        do_start(16'hFFFF, 2, 4);
        wait_drain(300);

        // parity vectors
        mem[16'h0200] = 8'h07; mem[16'h0201] = 8'h03;
        do_start(16'h0200, 2, 4);
        wait_drain(300);

        // start held across the done pulse: accepted only on the following cycle
        do_start(16'h0300, 1, 4);
        n = 0;
        while (!bus.done && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) report_unexpected("done_wait_timeout");
        bus.start = 1'b1; bus.base_addr = 16'h0400; bus.num_words = 16'd1;
        push_transfer(cyc + 2, 16'h0400, 1, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_late_start", bus.busy, 1);
        wait_drain(200);

        // randomized transfers
        for (int t = 0; t < 6; t++) begin
            num = $urandom_range(0, 3);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            do_start($urandom_range(0, 16'hFFFF), num, 4);
            wait_drain(num * PERIOD + 50);
        end

        // maximum length transfer aborted by reset in data bit 3 of the second frame
        b = $urandom_range(0, 16'hFFFF);
        mem[(b + 1) % (1 << ADDR_W)] = mem[(b + 1) % (1 << ADDR_W)] & 8'hF7;
        do_start(b, 16'hFFFF, 3);
        f2 = cyc + 3 + PERIOD;
        while (cyc < f2 + 4 * CPB + 1) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort_tx_line", bus.tx_line, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_mem_rd", bus.mem_rd, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin @(negedge clk); if (bus.done) cnt++; end
        check("done_after_abort", cnt, 0);

        // restart after abort
        do_start($urandom_range(0, 16'hFFFF), 2, 4);
        wait_drain(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
